// File: rtl/pu_wb_sram_arbiter.sv
// Shared weight-buffer SRAM read arbiter: round-robin over channels, fixed priority
// over streams inside a channel, with back-to-back chaining of a channel's streams.
module pu_wb_sram_arbiter #(
  parameter int NUM_CHANNELS    = 8,
  parameter int NUM_STREAMS     = 3,
  parameter int ADDR_W          = 32,
  parameter int LINE_BYTES_LOG2 = 10,
  parameter int WORD_BYTES_LOG2 = 2
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_STREAMS-1:0]                   stream_enable,
  input  logic [NUM_STREAMS*ADDR_W-1:0]            start_address,
  input  logic [NUM_CHANNELS*NUM_STREAMS*ADDR_W-1:0] word_counter,
  input  logic [NUM_CHANNELS*NUM_STREAMS-1:0]      word_read,
  output logic [NUM_CHANNELS*NUM_STREAMS-1:0]      word_ready,
  input  logic                                     WB_SRAM_ready,
  output logic                                     WB_SRAM_read,
  output logic [ADDR_W-1:0]                        WB_SRAM_address,
  output logic                                     busy
);

  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int ST_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                            state, state_n;
  logic [CH_W-1:0]                   turn, turn_n;
  logic [CH_W-1:0]                   cur_ch, cur_ch_n;
  logic [ST_W-1:0]                   cur_st, cur_st_n;
  logic [NUM_STREAMS-1:0]            served, served_n;
  logic                              read_n;
  logic [ADDR_W-1:0]                 addr_n;
  logic [NUM_CHANNELS*NUM_STREAMS-1:0] ready_n;

  logic [NUM_STREAMS-1:0]            pend [NUM_CHANNELS];
  logic                              scan_hit;
  logic [CH_W-1:0]                   scan_ch, scan_idx;
  logic [ST_W-1:0]                   scan_st;
  logic                              chain_hit;
  logic [ST_W-1:0]                   chain_st;
  logic                              issue;
  logic [CH_W-1:0]                   grant_ch;
  logic [ST_W-1:0]                   grant_st;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        pend[c][s] = word_read[c*NUM_STREAMS + s] & stream_enable[s];
      end
    end
  end

  // Walk downward so the channel closest to turn (in wrap order) is the last to win.
  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = '0;
    scan_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      scan_idx = turn + CH_W'(i);
      if (|pend[scan_idx]) begin
        scan_hit = 1'b1;
        scan_ch  = scan_idx;
      end
    end
  end

  always_comb begin
    scan_st = '0;
    for (int s = NUM_STREAMS - 1; s >= 0; s--) begin
      if (pend[scan_ch][s]) scan_st = ST_W'(s);
    end
  end

  always_comb begin
    chain_hit = 1'b0;
    chain_st  = '0;
    for (int s = NUM_STREAMS - 1; s >= 0; s--) begin
      if (pend[cur_ch][s] && !served[s] && (ST_W'(s) > cur_st)) begin
        chain_hit = 1'b1;
        chain_st  = ST_W'(s);
      end
    end
  end

  always_comb begin
    state_n  = state;
    turn_n   = turn;
    cur_ch_n = cur_ch;
    cur_st_n = cur_st;
    served_n = served;
    read_n   = WB_SRAM_read;
    addr_n   = WB_SRAM_address;
    ready_n  = '0;
    issue    = 1'b0;
    grant_ch = cur_ch;
    grant_st = cur_st;

    case (state)
      IDLE: begin
        read_n = 1'b0;
        if (scan_hit) begin
          issue    = 1'b1;
          grant_ch = scan_ch;
          grant_st = scan_st;
          served_n = NUM_STREAMS'(1) << scan_st;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (WB_SRAM_ready) begin
          ready_n[int'(cur_ch)*NUM_STREAMS + int'(cur_st)] = 1'b1;
          if (chain_hit) begin
            issue    = 1'b1;
            grant_st = chain_st;
            served_n = served | (NUM_STREAMS'(1) << chain_st);
          end else begin
            read_n  = 1'b0;
            state_n = IDLE;
            turn_n  = cur_ch + CH_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // The address is captured at grant time so later counter updates cannot disturb it.
    if (issue) begin
      read_n   = 1'b1;
      cur_ch_n = grant_ch;
      cur_st_n = grant_st;
      addr_n   = start_address[int'(grant_st)*ADDR_W +: ADDR_W]
               + (ADDR_W'(grant_ch) << LINE_BYTES_LOG2)
               + (word_counter[(int'(grant_ch)*NUM_STREAMS + int'(grant_st))*ADDR_W +: ADDR_W]
                  << WORD_BYTES_LOG2);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      turn            <= '0;
      cur_ch          <= '0;
      cur_st          <= '0;
      served          <= '0;
      WB_SRAM_read    <= 1'b0;
      WB_SRAM_address <= '0;
      word_ready      <= '0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      turn            <= turn_n;
      cur_ch          <= cur_ch_n;
      cur_st          <= cur_st_n;
      served          <= served_n;
      WB_SRAM_read    <= read_n;
      WB_SRAM_address <= addr_n;
      word_ready      <= ready_n;
      busy            <= (state_n == WAIT);
    end
  end

endmodule

// File: tb/tb_pu_wb_sram_arbiter.sv
// Directed bench for pu_wb_sram_arbiter: hand-computed addresses, grant order and
// ready pulses for the default 8-channel, 3-stream geometry.
module tb_pu_wb_sram_arbiter;

  localparam int NC = 8;
  localparam int NS = 3;
  localparam int AW = 32;

  logic               clock;
  logic               reset;
  logic [NS-1:0]      stream_enable;
  logic [NS*AW-1:0]   start_address;
  logic [NC*NS*AW-1:0] word_counter;
  logic [NC*NS-1:0]   word_read;
  logic [NC*NS-1:0]   word_ready;
  logic               WB_SRAM_ready;
  logic               WB_SRAM_read;
  logic [AW-1:0]      WB_SRAM_address;
  logic               busy;

  int checks = 0;
  int errors = 0;

  pu_wb_sram_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .stream_enable   (stream_enable),
    .start_address   (start_address),
    .word_counter    (word_counter),
    .word_read       (word_read),
    .word_ready      (word_ready),
    .WB_SRAM_ready   (WB_SRAM_ready),
    .WB_SRAM_read    (WB_SRAM_read),
    .WB_SRAM_address (WB_SRAM_address),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock edge and settle just after it, ready for checks and new inputs.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NC*NS-1:0] bit_at(input int idx);
    logic [NC*NS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  initial begin
    reset         = 1'b1;
    stream_enable = 3'b111;
    start_address = '0;
    word_counter  = '0;
    word_read     = '0;
    WB_SRAM_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    $display("[TB] reset state");
    checkOutput("rst_read", 64'(WB_SRAM_read), 64'd0);
    checkOutput("rst_addr", 64'(WB_SRAM_address), 64'd0);
    checkOutput("rst_ready", 64'(word_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);

    $display("[TB] address and single grant");
    reset = 1'b0;
    start_address[1*AW +: AW] = 32'h0000_1000;
    word_counter[7*AW +: AW]  = 32'd5;
    word_read = bit_at(7);
    applyStimulus();
    checkOutput("t1_read", 64'(WB_SRAM_read), 64'd1);
    checkOutput("t1_addr", 64'(WB_SRAM_address), 64'h1814);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("t1_hold_read", 64'(WB_SRAM_read), 64'd1);
    checkOutput("t1_hold_ready", 64'(word_ready), 64'd0);
    WB_SRAM_ready = 1'b1;
    applyStimulus();
    checkOutput("t1_pulse", 64'(word_ready), 64'(bit_at(7)));
    checkOutput("t1_done_read", 64'(WB_SRAM_read), 64'd0);
    checkOutput("t1_done_busy", 64'(busy), 64'd0);
    WB_SRAM_ready = 1'b0;
    word_read = '0;
    applyStimulus();
    checkOutput("t1_pulse_end", 64'(word_ready), 64'd0);

    // With turn at 3, channel 4 must beat channel 2.
    $display("[TB] turn advanced past channel 2");
    start_address = '0;
    word_counter  = '0;
    word_read = bit_at(6) | bit_at(12);
    applyStimulus();
    checkOutput("turn3_addr", 64'(WB_SRAM_address), 64'h1000);
    WB_SRAM_ready = 1'b1;
    word_read = '0;
    applyStimulus();
    checkOutput("turn3_pulse", 64'(word_ready), 64'(bit_at(12)));

    $display("[TB] skip-idle wrap");
    WB_SRAM_ready = 1'b0;
    word_read = bit_at(9) | bit_at(18);
    applyStimulus();
    checkOutput("wrap_first_read", 64'(WB_SRAM_read), 64'd1);
    checkOutput("wrap_first_addr", 64'(WB_SRAM_address), 64'h1800);
    WB_SRAM_ready = 1'b1;
    word_read = bit_at(9);
    applyStimulus();
    checkOutput("wrap_first_pulse", 64'(word_ready), 64'(bit_at(18)));
    WB_SRAM_ready = 1'b0;
    applyStimulus();
    checkOutput("wrap_second_read", 64'(WB_SRAM_read), 64'd1);
    checkOutput("wrap_second_addr", 64'(WB_SRAM_address), 64'h0C00);
    WB_SRAM_ready = 1'b1;
    word_read = '0;
    applyStimulus();
    checkOutput("wrap_second_pulse", 64'(word_ready), 64'(bit_at(9)));
    WB_SRAM_ready = 1'b0;

    $display("[TB] intra-channel chaining");
    start_address[0*AW +: AW] = 32'h100;
    start_address[1*AW +: AW] = 32'h200;
    start_address[2*AW +: AW] = 32'h300;
    word_read = bit_at(0) | bit_at(1) | bit_at(2);
    WB_SRAM_ready = 1'b1;
    applyStimulus();
    checkOutput("chain_s0_addr", 64'(WB_SRAM_address), 64'h100);
    checkOutput("chain_idle_no_pulse", 64'(word_ready), 64'd0);
    applyStimulus();
    checkOutput("chain_s1_addr", 64'(WB_SRAM_address), 64'h200);
    checkOutput("chain_s1_read", 64'(WB_SRAM_read), 64'd1);
    checkOutput("chain_pulse0", 64'(word_ready), 64'(bit_at(0)));
    applyStimulus();
    checkOutput("chain_s2_addr", 64'(WB_SRAM_address), 64'h300);
    checkOutput("chain_s2_read", 64'(WB_SRAM_read), 64'd1);
    checkOutput("chain_pulse1", 64'(word_ready), 64'(bit_at(1)));
    applyStimulus();
    checkOutput("chain_pulse2", 64'(word_ready), 64'(bit_at(2)));
    checkOutput("chain_no_reserve", 64'(WB_SRAM_read), 64'd0);
    WB_SRAM_ready = 1'b0;
    applyStimulus();
    checkOutput("chain_next_visit_addr", 64'(WB_SRAM_address), 64'h100);
    checkOutput("chain_next_visit_read", 64'(WB_SRAM_read), 64'd1);
    WB_SRAM_ready = 1'b1;
    word_read = '0;
    applyStimulus();
    checkOutput("chain_dropped_pulse", 64'(word_ready), 64'(bit_at(0)));
    checkOutput("chain_dropped_read", 64'(WB_SRAM_read), 64'd0);

    $display("[TB] enable mask");
    stream_enable = 3'b101;
    word_read = bit_at(12) | bit_at(13) | bit_at(14);
    applyStimulus();
    checkOutput("mask_s0_addr", 64'(WB_SRAM_address), 64'h1100);
    applyStimulus();
    checkOutput("mask_pulse0", 64'(word_ready), 64'(bit_at(12)));
    checkOutput("mask_s2_addr", 64'(WB_SRAM_address), 64'h1300);
    applyStimulus();
    checkOutput("mask_pulse2", 64'(word_ready), 64'(bit_at(14)));
    checkOutput("mask_done_read", 64'(WB_SRAM_read), 64'd0);
    word_read = '0;
    WB_SRAM_ready = 1'b0;
    stream_enable = 3'b111;
    applyStimulus();
    checkOutput("mask_quiet", 64'(word_ready), 64'd0);

    $display("[TB] reset mid-wait");
    word_read = bit_at(3);
    applyStimulus();
    checkOutput("rw_busy", 64'(busy), 64'd1);
    checkOutput("rw_addr", 64'(WB_SRAM_address), 64'h500);
    reset = 1'b1;
    WB_SRAM_ready = 1'b1;
    applyStimulus();
    checkOutput("rw_read", 64'(WB_SRAM_read), 64'd0);
    checkOutput("rw_addr_clr", 64'(WB_SRAM_address), 64'd0);
    checkOutput("rw_ready", 64'(word_ready), 64'd0);
    checkOutput("rw_busy_clr", 64'(busy), 64'd0);
    reset = 1'b0;
    WB_SRAM_ready = 1'b0;
    word_read = '0;
    applyStimulus();
    checkOutput("rw_no_late_pulse", 64'(word_ready), 64'd0);
    checkOutput("rw_idle_read", 64'(WB_SRAM_read), 64'd0);

    $display("[TB] wrap arithmetic");
    start_address[0*AW +: AW] = 32'hFFFF_FFF0;
    word_counter[0*AW +: AW]  = 32'd8;
    word_read = bit_at(0);
    applyStimulus();
    checkOutput("wa_addr", 64'(WB_SRAM_address), 64'h10);
    word_counter[0*AW +: AW]  = 32'd100;
    start_address[0*AW +: AW] = 32'h0;
    word_read = '0;
    applyStimulus();
    checkOutput("wa_addr_stable", 64'(WB_SRAM_address), 64'h10);
    WB_SRAM_ready = 1'b1;
    applyStimulus();
    checkOutput("wa_pulse", 64'(word_ready), 64'(bit_at(0)));
    checkOutput("wa_done_busy", 64'(busy), 64'd0);
    WB_SRAM_ready = 1'b0;
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_wb_sram_arbiter.md
Name: pu_wb_sram_arbiter

Overview:
- Parametrised successor of the PU weight-buffer SRAM read controller.
- Arbitrates one shared WB SRAM read port among NUM_CHANNELS input channels, each with NUM_STREAMS word-fetch streams (stream 0 = idx, 1 = repetition, 2 = unique by default).
- Generates tile-relative word addresses and returns one-cycle ready pulses to the requesting buffer.
- New versus the previous generation: single-cycle skip over idle channels, a per-stream enable mask, a configurable stream count and geometry, and a busy flag.

Parameters:
- NUM_CHANNELS, 8, number of input channels; must be at least 2 and a power of two.
- NUM_STREAMS, 3, streams per channel; stream index also sets priority, with 0 highest.
- ADDR_W, 32, width of addresses and word counters.
- LINE_BYTES_LOG2, 10, log2 of bytes per channel line in a tile.
- WORD_BYTES_LOG2, 2, log2 of bytes per SRAM word.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- stream_enable  in  NUM_STREAMS  per-stream grant enable; a 0 bit makes that stream's requests invisible.
- start_address  in  NUM_STREAMS*ADDR_W  tile start address per stream; stream s occupies bits [s*ADDR_W +: ADDR_W].
- word_counter  in  NUM_CHANNELS*NUM_STREAMS*ADDR_W  word index; entry for (c,s) sits at index c*NUM_STREAMS+s.
- word_read  in  NUM_CHANNELS*NUM_STREAMS  level request, same (c,s) indexing.
- word_ready  out  NUM_CHANNELS*NUM_STREAMS  one-cycle completion pulse, same indexing.
- WB_SRAM_ready  in  1  SRAM completion for the outstanding read.
- WB_SRAM_read  out  1  SRAM read request, held high until the read completes.
- WB_SRAM_address  out  ADDR_W  byte address of the outstanding read.
- busy  out  1  high while state is WAIT.

Behaviour:
- All outputs are registered.
- Reset values: WB_SRAM_read=0, WB_SRAM_address=0, word_ready=0, busy=0. Internal state: state=IDLE, turn=0, cur_ch=0, cur_st=0, served mask=0.
- Pending(c,s) = word_read[c,s] & stream_enable[s].
- Address(c,s) = start_address[s] + (c << LINE_BYTES_LOG2) + (word_counter[c,s] << WORD_BYTES_LOG2). The sum is truncated modulo 2^ADDR_W.
- word_ready defaults to 0 every cycle; it is never high for more than one cycle per grant.
- IDLE state:
  - Search channels turn, turn+1, ... with wrap-around and select the first channel with any pending stream.
  - Within that channel, select the lowest pending stream.
  - On a hit at edge t: WB_SRAM_read=1, WB_SRAM_address=Address, cur_ch/cur_st latched, served mask cleared then set for cur_st, state goes to WAIT. The request is visible after edge t.
  - On no hit: WB_SRAM_read=0 and turn is unchanged.
- WAIT state, WB_SRAM_ready=0: hold all outputs.
- WAIT state, WB_SRAM_ready=1 at edge t:
  - word_ready[cur_ch,cur_st]=1 for the cycle after edge t.
  - Then select the lowest stream s > cur_st that is pending in cur_ch and not in the served mask.
  - If one is found: issue it back-to-back at the same edge (WB_SRAM_read stays 1, address updates, cur_st=s, served mask updated).
  - Otherwise: WB_SRAM_read=0, state goes to IDLE, turn = (cur_ch+1) mod NUM_CHANNELS.
- Each stream of a channel is served at most once per channel visit. A requester that still holds word_read in the cycle its ready pulse is visible is not re-granted until its channel's next visit.
- WB_SRAM_ready sampled in IDLE is ignored; no pulse is produced.
- Once a request is issued it is completed even if word_read drops or stream_enable clears meanwhile; the ready pulse is still produced.
- Counter or start_address changes while in WAIT do not alter the outstanding address.
- Reset mid-WAIT returns everything to reset values at that edge, the outstanding read is abandoned, and no ready pulse is produced.
- Latency: request to SRAM = 1 cycle. SRAM ready to word_ready = 1 cycle. With zero-wait SRAM and all three streams pending, one channel visit costs 1 + 3 cycles.

Test Plan:
- Address and single grant: reset, then channel 2 stream 1 pending, start_address[1]=0x1000, counter=5.
  - Required: WB_SRAM_address=0x1814 and WB_SRAM_read=1 one cycle later.
  - Assert WB_SRAM_ready after 3 cycles: word_ready[7] pulses exactly 1 cycle, then WB_SRAM_read=0 and turn=3.
- Skip-idle wrap: turn=5, channels 3 and 6 pending.
  - Required: channel 6 granted first, channel 3 granted next, with no idle-scan cycles in between.
- Intra-channel chaining: channel 0, all 3 streams pending, WB_SRAM_ready held at 1.
  - Required: grants in order s0, s1, s2 on consecutive edges; 3 ready pulses; WB_SRAM_read stays high throughout.
  - The still-held s0 request is not re-served in the same visit.
- Enable mask: stream_enable=3'b101, channel 4 with all streams pending.
  - Required: only s0 and s2 are served; s1 gets no ready pulse.
- Reset mid-WAIT: assert reset while busy=1 with WB_SRAM_ready=1 on the same edge.
  - Required: all outputs at reset values; no word_ready pulse.
- Wrap arithmetic: start_address=0xFFFF_FFF0, channel 0, counter=8.
  - Required: WB_SRAM_address=0x0000_0010.
